i2c_burst_reader: RTL and testbench
===================================

# i2c_burst_reader

Parametrised burst-read sequencer that sits between system logic and the `i2c` master instance (`enable=1`). One `start` pulse makes it issue a run of single-register reads to consecutive (or strided) register addresses on one chip and store each returned word in an internal buffer. It adds multi-register bursts, address stride with 8-bit wrap, optional continuous re-polling, per-transaction timeout and error capture. The `i2c` master itself reads one register per `read_en` request.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `m_data_out` and of each buffer word.
- `DEPTH`, 16: buffer words, which is also the maximum burst length. Power of two, 2..256.
- `GAP_CYCLES`, 10: idle `clk` cycles between consecutive master requests. 0 is legal.
- `TIMEOUT_CYCLES`, 4095: cycles allowed for `m_busy` to rise, and separately for it to fall.

Ports:
- `clk` in 1: single clock, the same clock as the `i2c` master.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Ignored while `busy`=1.
- `chip_addr` in 7: target chip. Captured on accepted `start`.
- `base_reg_addr` in 8: first register. Captured on accepted `start`.
- `count` in $clog2(DEPTH)+1: words per burst. Captured on accepted `start`. Legal range 1..DEPTH.
- `stride` in 8: register address increment. Captured on accepted `start`.
- `continuous` in 1: captured on accepted `start`. When 1, a new burst restarts automatically after each burst completes.
- `stop` in 1: ends continuous mode after the current burst.
- `m_chip_addr` out 7, `m_reg_addr` out 8, `m_read_en` out 1: request to the master.
- `m_busy` in 1, `m_status` in 4, `m_data_out` in DATA_WIDTH: response from the master.
- `rd_addr` in $clog2(DEPTH), `rd_data` out DATA_WIDTH: buffer read port, registered, 1-cycle latency.
- `busy` out 1, `done` out 1, `error` out 1, `err_index` out $clog2(DEPTH), `err_status` out 4, `words_valid` out $clog2(DEPTH)+1, `burst_count` out 16.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, STORE, GAP, FINISH.
- IDLE:
  - `start`=1 captures all inputs, clears the index `idx` to 0 and clears `words_valid`, then goes to ISSUE.
  - `start` with `count`=0 or `count`>DEPTH: no transfer. `error` is set, `err_status`=4'hF and `done` pulses, all in the next cycle.
- ISSUE:
  - Drives `m_chip_addr`, `m_reg_addr`=cur_addr and `m_read_en`=1 for exactly one cycle, then goes to WAIT_ACK.
  - `m_chip_addr` and `m_reg_addr` hold their values until the next ISSUE.
- WAIT_ACK:
  - `m_busy`=1 goes to WAIT_DONE.
  - TIMEOUT_CYCLES elapsed without `m_busy` gives an error with `err_status`=4'hE.
- WAIT_DONE:
  - `m_busy`=0 goes to STORE.
  - TIMEOUT_CYCLES elapsed gives an error with `err_status`=4'hD.
- STORE:
  - `m_status`≠0 gives an error with `err_status`=`m_status`.
  - Otherwise `buf[idx]`←`m_data_out`, `words_valid`←idx+1, cur_addr←(cur_addr+stride) mod 256, idx←idx+1.
  - If idx+1 == count, go to FINISH; otherwise go to GAP.
- GAP: waits GAP_CYCLES, then goes to ISSUE. GAP_CYCLES=0 goes straight to ISSUE.
- FINISH:
  - `done` pulses 1 cycle and `burst_count` increments, wrapping at 2^16.
  - If `continuous`=1 and no `stop` has been latched: reload cur_addr=base, idx=0, keep the buffer contents, go to GAP.
  - Otherwise go to IDLE.
- Any error:
  - Sets `error` (sticky until the next accepted `start` or `reset`).
  - Loads `err_index`=idx and pulses `done`.
  - Goes to IDLE. Continuous mode is abandoned.
- `stop`:
  - Latched whenever `busy`=1; cleared on accepted `start`.
  - Never aborts a transaction that is in flight.
- `busy`=1 in every state except IDLE.
- Reset mid-burst: state returns to IDLE. Buffer contents are undefined, but `words_valid`=0 tells the user not to read them.

## Timing
- Reset values:
  - `busy`, `done`, `error`, `m_read_en` = 0.
  - `m_chip_addr`, `m_reg_addr`, `err_index`, `err_status` = 0.
  - `words_valid`, `burst_count`, `rd_data` = 0.
- Accepted `start` at cycle T: `m_read_en`=1 in T+1 only; `busy`=1 from T+1.
- The master raises `m_busy` within 2 cycles of `read_en`. The sequencer tolerates up to TIMEOUT_CYCLES.
- `m_data_out` is sampled in the first cycle after `m_busy` falls.
- Per-word overhead beyond the I2C transaction: 1 (ISSUE) + 1 (STORE) + GAP_CYCLES.
- `done` pulse and the final `words_valid` update occur in the same cycle.
- `rd_data` is valid one cycle after `rd_addr`. A read of an index ≥ `words_valid` returns stale data.

## Test plan
- **Basic burst.** Slave regs 0x00=A1A1, 0x01=B2B2. Start with chip 0x0F, base 0x00, count 2, stride 1.
  - Required: `done` after 2 transactions, buffer[0]=A1A1, buffer[1]=B2B2, `words_valid`=2, `error`=0.
- **Stride and wrap.** Start with base 0xFE, stride 1, count 3.
  - Required: master requests go to 0xFE, 0xFF, 0x00.
- **NACK.** Wrong chip 0x10; master returns `m_status`=4'h1.
  - Required: `error`=1, `err_index`=0, `err_status`=1, `words_valid`=0.
- **Continuous with stop.** Start with `continuous`=1, count 2; assert `stop` mid-second burst.
  - Required: `burst_count`=2, then IDLE with no third `m_read_en`.
- **Timeout and illegal count.**
  - Hold `m_busy`=0 with TIMEOUT_CYCLES=50: required `err_status`=4'hE 51 cycles after `read_en`.
  - Start with `count`=0: required immediate `done` with `err_status`=4'hF.
- **Reset mid-burst.**
  - Required: all outputs at reset values the next cycle, and a following start behaves identically to the basic burst case.

Source files
------------

// File: rtl/i2c_burst_reader.sv
// Burst-read sequencer in front of a single-register i2c master: issues a run of strided
// register reads on one chip, buffers the returned words, optionally re-polls continuously.
module i2c_burst_reader #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned GAP_CYCLES     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 4095,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [6:0]            chip_addr,
   input  logic [7:0]            base_reg_addr,
   input  logic [CW-1:0]         count,
   input  logic [7:0]            stride,
   input  logic                  continuous,
   input  logic                  stop,
   output logic [6:0]            m_chip_addr,
   output logic [7:0]            m_reg_addr,
   output logic                  m_read_en,
   input  logic                  m_busy,
   input  logic [3:0]            m_status,
   input  logic [DATA_WIDTH-1:0] m_data_out,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [AW-1:0]         err_index,
   output logic [3:0]            err_status,
   output logic [CW-1:0]         words_valid,
   output logic [15:0]           burst_count
);

   typedef enum logic [2:0] {
      StIdle, StIssue, StWaitAck, StWaitDone, StStore, StGap, StFinish
   } state_e;

   localparam logic [CW-1:0] DepthC      = CW'(DEPTH);
   localparam logic [31:0]   TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]   GapLast     = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

   state_e                  state_q;
   logic [6:0]              chip_q;
   logic [7:0]              base_q, stride_q, cur_addr_q;
   logic [CW-1:0]           count_q, words_valid_q;
   logic                    cont_q, stop_q;
   logic [AW-1:0]           idx_q, err_index_q;
   logic [31:0]             tmr_q;
   logic [6:0]              m_chip_addr_q;
   logic [7:0]              m_reg_addr_q;
   logic                    m_read_en_q, done_q, error_q;
   logic [3:0]              err_status_q;
   logic [15:0]             burst_count_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [CW-1:0] idx_nxt;
   logic          cnt_bad, restart;
   logic          go, fail;
   logic [7:0]    go_addr;
   logic [6:0]    go_chip;
   logic [3:0]    fail_st;

   assign idx_nxt = {1'b0, idx_q} + CW'(1);
   assign cnt_bad = (count == '0) || (count > DepthC);
   assign restart = cont_q && !stop_q && !stop;

   // Shared decode of "launch a master request" and "abort with error" for the FSM below.
   always_comb begin
      go      = 1'b0;
      go_addr = cur_addr_q;
      go_chip = chip_q;
      fail    = 1'b0;
      fail_st = 4'h0;
      unique case (state_q)
         StIdle: begin
            if (start && !cnt_bad) begin
               go      = 1'b1;
               go_addr = base_reg_addr;
               go_chip = chip_addr;
            end
         end
         StWaitAck: begin
            if (!m_busy && tmr_q == TimeoutLast) begin
               fail    = 1'b1;
               fail_st = 4'hE;
            end
         end
         StWaitDone: begin
            if (m_busy && tmr_q == TimeoutLast) begin
               fail    = 1'b1;
               fail_st = 4'hD;
            end
         end
         StStore: begin
            if (m_status != 4'h0) begin
               fail    = 1'b1;
               fail_st = m_status;
            end else if (idx_nxt != count_q && GAP_CYCLES == 0) begin
               go      = 1'b1;
               go_addr = cur_addr_q + stride_q;
            end
         end
         StGap: go = (tmr_q == GapLast);
         StFinish: begin
            if (restart && GAP_CYCLES == 0) begin
               go      = 1'b1;
               go_addr = base_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         chip_q        <= '0;
         base_q        <= '0;
         stride_q      <= '0;
         cur_addr_q    <= '0;
         count_q       <= '0;
         cont_q        <= 1'b0;
         stop_q        <= 1'b0;
         idx_q         <= '0;
         tmr_q         <= '0;
         m_chip_addr_q <= '0;
         m_reg_addr_q  <= '0;
         m_read_en_q   <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         err_index_q   <= '0;
         err_status_q  <= '0;
         words_valid_q <= '0;
         burst_count_q <= '0;
      end else begin
         done_q      <= 1'b0;
         m_read_en_q <= 1'b0;
         if (state_q != StIdle && stop) stop_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  chip_q        <= chip_addr;
                  base_q        <= base_reg_addr;
                  stride_q      <= stride;
                  count_q       <= count;
                  cont_q        <= continuous;
                  stop_q        <= 1'b0;
                  idx_q         <= '0;
                  words_valid_q <= '0;
                  cur_addr_q    <= base_reg_addr;
                  error_q       <= cnt_bad;
                  if (cnt_bad) begin
                     err_status_q <= 4'hF;
                     err_index_q  <= '0;
                     done_q       <= 1'b1;
                  end
               end
            end
            StIssue: begin
               state_q <= StWaitAck;
               tmr_q   <= '0;
            end
            StWaitAck: begin
               if (m_busy) begin
                  state_q <= StWaitDone;
                  tmr_q   <= '0;
               end else begin
                  tmr_q <= tmr_q + 32'd1;
               end
            end
            StWaitDone: begin
               if (!m_busy) state_q <= StStore;
               else         tmr_q   <= tmr_q + 32'd1;
            end
            StStore: begin
               if (m_status == 4'h0) begin
                  words_valid_q <= idx_nxt;
                  cur_addr_q    <= cur_addr_q + stride_q;
                  idx_q         <= idx_q + AW'(1);
                  if (idx_nxt == count_q) begin
                     state_q       <= StFinish;
                     done_q        <= 1'b1;
                     burst_count_q <= burst_count_q + 16'd1;
                  end else begin
                     state_q <= StGap;
                     tmr_q   <= '0;
                  end
               end
            end
            StGap: tmr_q <= tmr_q + 32'd1;
            StFinish: begin
               if (restart) begin
                  cur_addr_q <= base_q;
                  idx_q      <= '0;
                  state_q    <= StGap;
                  tmr_q      <= '0;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (go) begin
            state_q       <= StIssue;
            m_read_en_q   <= 1'b1;
            m_reg_addr_q  <= go_addr;
            m_chip_addr_q <= go_chip;
         end
         if (fail) begin
            state_q      <= StIdle;
            error_q      <= 1'b1;
            err_status_q <= fail_st;
            err_index_q  <= idx_q;
            done_q       <= 1'b1;
         end
      end
   end

   // Buffer array is not reset; words_valid tells the user which entries are meaningful.
   always_ff @(posedge clk) begin
      if (state_q == StStore && m_status == 4'h0) mem_q[idx_q] <= m_data_out;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= mem_q[rd_addr];
   end

   assign m_chip_addr = m_chip_addr_q;
   assign m_reg_addr  = m_reg_addr_q;
   assign m_read_en   = m_read_en_q;
   assign rd_data     = rd_data_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign error       = error_q;
   assign err_index   = err_index_q;
   assign err_status  = err_status_q;
   assign words_valid = words_valid_q;
   assign burst_count = burst_count_q;

endmodule

// File: tb/tb_i2c_burst_reader.sv
// Bench for i2c_burst_reader: behavioural i2c master/slave model, vector table of bursts,
// plus hand-written continuous, timeout and mid-burst reset sequences.
module tb_i2c_burst_reader;

   localparam int unsigned DW  = 16;
   localparam int unsigned DEP = 4;
   localparam int unsigned GAP = 2;
   localparam int unsigned TO  = 50;
   localparam int unsigned AW  = 2;
   localparam int unsigned CW  = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [6:0]    chip_addr = '0;
   logic [7:0]    base_reg_addr = '0;
   logic [CW-1:0] count = '0;
   logic [7:0]    stride = '0;
   logic          continuous = 1'b0;
   logic          stop = 1'b0;
   logic [6:0]    m_chip_addr;
   logic [7:0]    m_reg_addr;
   logic          m_read_en;
   logic          m_busy;
   logic [3:0]    m_status;
   logic [DW-1:0] m_data_out;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          busy, done, error;
   logic [AW-1:0] err_index;
   logic [3:0]    err_status;
   logic [CW-1:0] words_valid;
   logic [15:0]   burst_count;

   always #5 clk = ~clk;

   i2c_burst_reader #(
      .DATA_WIDTH(DW), .DEPTH(DEP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .chip_addr(chip_addr),
      .base_reg_addr(base_reg_addr), .count(count), .stride(stride),
      .continuous(continuous), .stop(stop), .m_chip_addr(m_chip_addr),
      .m_reg_addr(m_reg_addr), .m_read_en(m_read_en), .m_busy(m_busy),
      .m_status(m_status), .m_data_out(m_data_out), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .error(error), .err_index(err_index),
      .err_status(err_status), .words_valid(words_valid), .burst_count(burst_count)
   );

   // Master + slave model: chip 0x0F answers from regs[], any other chip NACKs.
   logic [15:0] regs [256];
   logic [7:0]  req_log [256];
   int          req_n = 0;
   logic        mute = 1'b0;
   int          mph;

   always @(posedge clk) begin
      if (reset) begin
         m_busy     <= 1'b0;
         m_status   <= 4'h0;
         m_data_out <= '0;
         mph        <= 0;
      end else if (m_read_en) begin
         req_log[8'(req_n)] <= m_reg_addr;
         req_n              <= req_n + 1;
         if (!mute) begin
            mph        <= 1;
            m_data_out <= (m_chip_addr == 7'h0F) ? regs[m_reg_addr] : 16'h0000;
            m_status   <= (m_chip_addr == 7'h0F) ? 4'h0 : 4'h1;
         end
      end else if (mph == 1) begin
         m_busy <= 1'b1;
         mph    <= 2;
      end else if (mph >= 2 && mph < 4) begin
         mph <= mph + 1;
      end else if (mph == 4) begin
         m_busy <= 1'b0;
         mph    <= 0;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s_%s: got 0x%0h expected 0x%0h", tag, nm, act, exp);
      end
   endtask

   task automatic wait_done(input int budget, output logic seen);
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_reset(input string tag);
      check(tag, "busy", 32'(busy), 32'd0);
      check(tag, "done", 32'(done), 32'd0);
      check(tag, "error", 32'(error), 32'd0);
      check(tag, "read_en", 32'(m_read_en), 32'd0);
      check(tag, "m_chip", 32'(m_chip_addr), 32'd0);
      check(tag, "m_reg", 32'(m_reg_addr), 32'd0);
      check(tag, "err_index", 32'(err_index), 32'd0);
      check(tag, "err_status", 32'(err_status), 32'd0);
      check(tag, "words_valid", 32'(words_valid), 32'd0);
      check(tag, "burst_count", 32'(burst_count), 32'd0);
      check(tag, "rd_data", 32'(rd_data), 32'd0);
   endtask

   typedef struct {
      logic [6:0]    chip;
      logic [7:0]    base;
      logic [CW-1:0] cnt;
      logic [7:0]    stride;
      logic          exp_err;
      logic [3:0]    exp_st;
      logic [CW-1:0] exp_words;
      int            exp_reqs;
   } vec_t;

   vec_t vecs [7];

   task automatic run_vec(input vec_t v, input string tag);
      int         n0;
      logic       seen;
      logic [7:0] a;
      n0 = req_n;
      @(negedge clk);
      chip_addr     = v.chip;
      base_reg_addr = v.base;
      count         = v.cnt;
      stride        = v.stride;
      continuous    = 1'b0;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (v.exp_reqs == 0) begin
         check(tag, "imm_done", 32'(done), 32'd1);
         check(tag, "idle_busy", 32'(busy), 32'd0);
      end else begin
         check(tag, "read_en_t1", 32'(m_read_en), 32'd1);
         check(tag, "busy_t1", 32'(busy), 32'd1);
         wait_done(400, seen);
         check(tag, "done_seen", 32'(seen), 32'd1);
      end
      check(tag, "error", 32'(error), 32'(v.exp_err));
      if (v.exp_err) begin
         check(tag, "err_status", 32'(err_status), 32'(v.exp_st));
         check(tag, "err_index", 32'(err_index), 32'd0);
      end
      check(tag, "words_valid", 32'(words_valid), 32'(v.exp_words));
      check(tag, "req_count", 32'(req_n - n0), 32'(v.exp_reqs));
      a = v.base;
      for (int i = 0; i < v.exp_reqs; i++) begin
         check(tag, $sformatf("req%0d", i), 32'(req_log[8'(n0 + i)]), 32'(a));
         a = a + v.stride;
      end
      a = v.base;
      for (int i = 0; i < int'(v.exp_words); i++) begin
         rd_addr = AW'(i);
         @(negedge clk);
         check(tag, $sformatf("buf%0d", i), 32'(rd_data), 32'(regs[a]));
         a = a + v.stride;
      end
   endtask

   initial begin
      int         n0;
      int         bc0;
      logic       seen;
      logic       found;
      for (int i = 0; i < 256; i++) regs[i] = {8'(i) ^ 8'h5A, 8'(i)};
      regs[0] = 16'hA1A1;
      regs[1] = 16'hB2B2;

      //            chip   base   cnt   stride err st     words reqs
      vecs[0] = '{7'h0F, 8'h00, 3'd2, 8'h01, 1'b0, 4'h0, 3'd2, 2};
      vecs[1] = '{7'h0F, 8'hFE, 3'd3, 8'h01, 1'b0, 4'h0, 3'd3, 3};
      vecs[2] = '{7'h10, 8'h00, 3'd2, 8'h01, 1'b1, 4'h1, 3'd0, 1};
      vecs[3] = '{7'h0F, 8'h10, 3'd4, 8'h03, 1'b0, 4'h0, 3'd4, 4};
      vecs[4] = '{7'h0F, 8'h00, 3'd0, 8'h01, 1'b1, 4'hF, 3'd0, 0};
      vecs[5] = '{7'h0F, 8'h00, 3'd5, 8'h01, 1'b1, 4'hF, 3'd0, 0};
      vecs[6] = '{7'h0F, 8'hF0, 3'd1, 8'h20, 1'b0, 4'h0, 3'd1, 1};

      repeat (3) @(negedge clk);
      check_reset("init");
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));
      check("table", "burst_count", 32'(burst_count), 32'd4);

      // Continuous mode, stop raised during the second burst.
      bc0 = int'(burst_count);
      n0  = req_n;
      @(negedge clk);
      chip_addr = 7'h0F; base_reg_addr = 8'h00; count = 3'd2; stride = 8'h01;
      continuous = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(400, seen);
      check("cont", "done1", 32'(seen), 32'd1);
      check("cont", "bc1", 32'(burst_count), 32'(bc0 + 1));
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (req_n >= n0 + 3) begin
            found = 1'b1;
            break;
         end
      end
      check("cont", "second_burst", 32'(found), 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_done(400, seen);
      check("cont", "done2", 32'(seen), 32'd1);
      check("cont", "bc2", 32'(burst_count), 32'(bc0 + 2));
      repeat (40) @(negedge clk);
      check("cont", "idle", 32'(busy), 32'd0);
      check("cont", "no_third", 32'(req_n - n0), 32'd4);
      continuous = 1'b0;

      // Ack timeout: master never raises busy.
      mute = 1'b1;
      @(negedge clk);
      chip_addr = 7'h0F; base_reg_addr = 8'h20; count = 3'd1; stride = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("tmo", "read_en", 32'(m_read_en), 32'd1);
      repeat (50) @(negedge clk);
      check("tmo", "not_yet", 32'(error), 32'd0);
      @(negedge clk);
      check("tmo", "error", 32'(error), 32'd1);
      check("tmo", "err_status", 32'(err_status), 32'hE);
      check("tmo", "done", 32'(done), 32'd1);
      check("tmo", "busy", 32'(busy), 32'd0);
      mute = 1'b0;

      // Reset while a transaction is in flight.
      @(negedge clk);
      chip_addr = 7'h0F; base_reg_addr = 8'h00; count = 3'd2; stride = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (m_busy) begin
            found = 1'b1;
            break;
         end
      end
      check("rst", "in_flight", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_reset("rst");
      reset = 1'b0;
      run_vec(vecs[0], "after_rst");
      check("after_rst", "burst_count", 32'(burst_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
